// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the EX-stage controller and the HI/LO multiply/divide unit.
// The master drives the request and cancel, and the slave returns busy and the HI/LO write port.
interface hilo_muldiv_if #(
   parameter int DATA_W = 32
);
   logic              start;
   logic [1:0]        op;
   logic [DATA_W-1:0] opA;
   logic [DATA_W-1:0] opB;
   logic              cancel;
   logic              busy;
   logic [DATA_W-1:0] wHiData;
   logic [DATA_W-1:0] wLoData;
   logic              whi;
   logic              wlo;

   modport master (
      output start, op, opA, opB, cancel,
      input  busy, wHiData, wLoData, whi, wlo
   );

   modport slave (
      input  start, op, opA, opB, cancel,
      output busy, wHiData, wLoData, whi, wlo
   );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO register pair.
// Multiply takes one cycle; divide is radix-2 restoring on magnitudes, followed by a sign fix-up cycle.
module hilo_muldiv #(
   parameter int DATA_W = 32
) (
   input logic          clk,
   input logic          rst,
   hilo_muldiv_if.slave bus
);
   localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   state_t state, state_n;

   logic [1:0]        op_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic [DATA_W-1:0] quo, rem, dvs;
   logic [DATA_W-1:0] hi_q, lo_q;
   logic [CNT_W-1:0]  cnt;

   logic                     accept;
   logic                     last_iter;
   logic signed [DATA_W:0]   mul_a, mul_b;
   logic signed [PROD_W-1:0] prod;
   logic [DATA_W:0]          rem_sh, diff;
   logic                     q_bit;
   logic [DATA_W-1:0]        rem_next;
   logic                     sign_a, sign_b, div_zero;

   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
      return neg ? (~v + DATA_W'(1)) : v;
   endfunction

   // Magnitude of the most negative value comes out as unsigned 2^(DATA_W-1).
   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic is_signed);
      return cond_neg(v, is_signed & v[DATA_W-1]);
   endfunction

   // A 1-bit extension selects signed or unsigned, so one signed multiplier covers MULT and MULTU.
   assign mul_a = $signed({~op_q[0] & a_q[DATA_W-1], a_q});
   assign mul_b = $signed({~op_q[0] & b_q[DATA_W-1], b_q});
   assign prod  = PROD_W'(mul_a) * PROD_W'(mul_b);

   assign rem_sh   = {rem, quo[DATA_W-1]};
   assign diff     = rem_sh - {1'b0, dvs};
   assign q_bit    = ~diff[DATA_W];
   assign rem_next = q_bit ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];

   assign sign_a    = ~op_q[0] & a_q[DATA_W-1];
   assign sign_b    = ~op_q[0] & b_q[DATA_W-1];
   assign div_zero  = (b_q == '0);
   assign last_iter = (cnt == CNT_W'(DATA_W - 1));

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.cancel) begin
               accept  = 1'b1;
               state_n = bus.op[1] ? DIV : MUL;
            end
         end
         MUL:     state_n = bus.cancel ? IDLE : DONE;
         DIV: begin
            if (bus.cancel)     state_n = IDLE;
            else if (last_iter) state_n = FIX;
         end
         FIX:     state_n = bus.cancel ? IDLE : DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         quo  <= '0;
         rem  <= '0;
         dvs  <= '0;
         cnt  <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (accept) begin
            op_q <= bus.op;
            a_q  <= bus.opA;
            b_q  <= bus.opB;
            quo  <= magnitude(bus.opA, ~bus.op[0]);
            dvs  <= magnitude(bus.opB, ~bus.op[0]);
            rem  <= '0;
            cnt  <= '0;
         end
         case (state)
            MUL: begin
               if (!bus.cancel) {hi_q, lo_q} <= prod;
            end
            DIV: begin
               rem <= rem_next;
               quo <= {quo[DATA_W-2:0], q_bit};
               cnt <= cnt + CNT_W'(1);
            end
            FIX: begin
               if (!bus.cancel) begin
                  if (div_zero) begin
                     hi_q <= a_q;
                     lo_q <= '1;
                  end else begin
                     hi_q <= cond_neg(rem, sign_a);
                     lo_q <= cond_neg(quo, sign_a ^ sign_b);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (state == MUL) || (state == DIV) || (state == FIX);
   assign bus.whi     = (state == DONE);
   assign bus.wlo     = (state == DONE);
   assign bus.wHiData = hi_q;
   assign bus.wLoData = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: reset, MULT/MULTU, DIV/DIVU corner cases, cancel, reset abort, start hold.
module tb_hilo_muldiv;
   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   hilo_muldiv_if #(.DATA_W(32)) bus ();

   hilo_muldiv #(.DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one operation, optionally pulses a stray MULT start at cycle inj, and checks the result.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int elat, input int inj);
      int          busy_n;
      int          lat;
      int          stray;
      logic        got;
      logic        wl;
      logic        bz;
      logic [31:0] hi;
      logic [31:0] lo;
      busy_n = 0; lat = 0; stray = 0; got = 1'b0; wl = 1'b0; bz = 1'b1; hi = '0; lo = '0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = o; bus.opA = a; bus.opB = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         if (bus.busy) busy_n++;
         if (k == inj) begin
            bus.start = 1'b1; bus.op = 2'b00; bus.opA = 32'd5; bus.opB = 32'd6;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         if (bus.whi) begin
            got = 1'b1; lat = k; hi = bus.wHiData; lo = bus.wLoData; wl = bus.wlo; bz = bus.busy;
            break;
         end
      end
      bus.start = 1'b0;
      chk({tag, "_pulse"}, 64'(got), 64'd1);
      chk({tag, "_lat"}, 64'(lat), 64'(elat));
      chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(elat));
      chk({tag, "_hi"}, 64'(hi), 64'(eh));
      chk({tag, "_lo"}, 64'(lo), 64'(el));
      chk({tag, "_wlo"}, 64'(wl), 64'd1);
      chk({tag, "_busy_at_pulse"}, 64'(bz), 64'd0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (bus.whi || bus.wlo) stray++;
      end
      chk({tag, "_no_extra_pulse"}, 64'(stray), 64'd0);
   endtask

   initial begin
      int pulses;
      int stray;
      rst = 1'b0;
      bus.start = 1'b0; bus.op = 2'b00; bus.opA = '0; bus.opB = '0; bus.cancel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_whi", 64'(bus.whi), 64'd0);
      chk("rst_wlo", 64'(bus.wlo), 64'd0);
      chk("rst_hi", 64'(bus.wHiData), 64'd0);
      chk("rst_lo", 64'(bus.wLoData), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_busy", 64'(bus.busy), 64'd0);

      run_op("mult_neg", 2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1, 0);
      run_op("multu", 2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1, 0);
      run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0);
      run_op("div_negb", 2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 0);
      run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, 10);
      run_op("divu_zero", 2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 33, 0);
      run_op("div_zero", 2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 33, 0);
      run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 0);

      // cancel mid-divide: no write pulse, busy drops next cycle
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 2'b10; bus.opA = 32'hFFFFFFF9; bus.opB = 32'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("cancel_busy_before", 64'(bus.busy), 64'd1);
      bus.cancel = 1'b1;
      @(posedge clk); #1;
      bus.cancel = 1'b0;
      chk("cancel_busy_after", 64'(bus.busy), 64'd0);
      stray = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (bus.whi) stray++;
      end
      chk("cancel_no_pulse", 64'(stray), 64'd0);
      run_op("multu_after_cancel", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1, 0);

      // reset mid-divide: aborts without a pulse and clears the output registers
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 2'b11; bus.opA = 32'd100; bus.opB = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_hi", 64'(bus.wHiData), 64'd0);
      chk("midrst_lo", 64'(bus.wLoData), 64'd0);
      stray = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (bus.whi) stray++;
      end
      chk("midrst_no_pulse", 64'(stray), 64'd0);

      // start held high across two MULTs: second accepted only after DONE
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 2'b00; bus.opA = 32'd3; bus.opB = 32'd4;
      @(posedge clk); #1;
      bus.opA = 32'hFFFFFFFD; bus.opB = 32'd5;
      pulses = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (k == 3) bus.start = 1'b0;
         if (bus.whi) begin
            pulses++;
            if (pulses == 1) begin
               chk("hold_first_lat", 64'(k), 64'd1);
               chk("hold_first_hi", 64'(bus.wHiData), 64'd0);
               chk("hold_first_lo", 64'(bus.wLoData), 64'd12);
            end else if (pulses == 2) begin
               chk("hold_second_lat", 64'(k), 64'd4);
               chk("hold_second_hi", 64'(bus.wHiData), 64'hFFFFFFFF);
               chk("hold_second_lo", 64'(bus.wLoData), 64'hFFFFFFF1);
            end
         end
      end
      bus.start = 1'b0;
      chk("hold_pulse_count", 64'(pulses), 64'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage; sits directly upstream of the HI/LO register pair and produces its write data and write enables.
- Executes MULT, MULTU, DIV and DIVU on two operands.
- Returns a 64-bit product as {HI,LO}, or remainder→HI and quotient→LO.
- Raises busy so the pipeline controller can stall while an operation is in flight.

Parameters:
- DATA_W, 32, operand width and HI/LO width. The division iteration count equals DATA_W.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset); sampled on the rising edge of clk.
- start  input  1  request a new operation; accepted only in IDLE.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opA  input  DATA_W  rs operand (multiplicand / dividend).
- opB  input  DATA_W  rt operand (multiplier / divisor).
- cancel  input  1  pipeline flush; aborts the operation in flight.
- busy  output  1  high while in MUL, DIV or FIX.
- wHiData  output  DATA_W  HI write data.
- wLoData  output  DATA_W  LO write data.
- whi  output  1  HI write enable; one-cycle pulse.
- wlo  output  1  LO write enable; one-cycle pulse, always equal to whi.

Behaviour:
- Reset (rst=0 at an edge):
  - state goes to IDLE;
  - busy, whi and wlo are 0;
  - wHiData and wLoData are 0;
  - all internal registers are cleared.
  - Reset takes priority over cancel and start, and aborts any operation mid-flight without a write pulse.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - If start=1 and cancel=0, latch op, opA and opB.
  - Go to MUL for op=0x; go to DIV for op=1x.
  - start in any other state is ignored, and no queueing takes place.
- MUL (1 cycle):
  - Compute the full 2·DATA_W product, signed for MULT and unsigned for MULTU.
  - Register HI = upper half and LO = lower half, then go to DONE.
- DIV (DATA_W cycles):
  - Radix-2 restoring division on operand magnitudes. For DIV, magnitude = two's-complement absolute value; 0x80000000 is treated as unsigned 2^31.
  - Each cycle shifts in one quotient bit.
  - An iteration counter counts 0..DATA_W-1; go to FIX when it reaches DATA_W-1.
- FIX (1 cycle), sign correction for DIV:
  - quotient negated if sign(opA) xor sign(opB);
  - remainder negated if sign(opA).
  - DIVU takes no correction. Go to DONE.
- DONE (1 cycle): whi=wlo=1, wHiData/wLoData hold the result, busy=0. Go to IDLE unconditionally.
- Outputs hold their last values while whi=0. The consumer must only look at them when whi=1.
- Latency, with start accepted at edge E0:
  - MUL: whi high in the cycle after edge E0+1.
  - DIV/DIVU: whi high in the cycle after edge E0+DATA_W+1 (edge 33 for DATA_W=32).
  - busy is high in the cycles after E0 through the FIX cycle.
  - A new start is first accepted in the cycle after DONE.
- Divide by zero (opB=0, DIV or DIVU):
  - takes the normal latency;
  - result is forced in FIX to LO=all ones and HI=opA, with no sign correction.
- Overflow 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0. This falls out of the magnitude arithmetic and needs no special case.
- cancel=1 in MUL, DIV or FIX:
  - next state is IDLE, no whi/wlo pulse;
  - busy drops in the following cycle.
- cancel in DONE has no effect; the pulse is already issued.
- cancel=1 together with start in IDLE: start is ignored.

Test Plan:
- Reset with rst=0 for 2 cycles, then release → busy=0, whi=wlo=0, wHiData=wLoData=0. Reset asserted mid-DIV at cycle 10 → IDLE, no write pulse.
- MULT opA=0xFFFFFFFE (−2), opB=0x00000003 → whi/wlo pulse 2 cycles after start, HI=0xFFFFFFFF, LO=0xFFFFFFFA. The same operands with MULTU → HI=0x00000002, LO=0xFFFFFFFA.
- DIV opA=0xFFFFFFF9 (−7), opB=0x00000002 → pulse at cycle 34, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1), busy high for exactly 33 cycles. DIVU 100/7 → LO=14, HI=2.
- DIVU opA=0x12345678, opB=0 → LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Start DIV, assert cancel at cycle 5 → no whi pulse ever, busy=0 one cycle later. A new MULTU 3×5 issued next → HI=0, LO=15.
- Hold start=1 continuously across two MULTs with different operands → second accepted only after DONE, exactly two pulses, each with the correct result. A start pulse during DIV is ignored.
